// File: rtl/ov7670_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ov7670_pkg                                                                 |
// | Shared definitions for the OV7670 SCCB register-table initialiser: the     |
// | sequencer state enum, the special ROM entry codes, the COM7 soft-reset     |
// | register, and a helper that selects the byte sent in each write phase.     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package ov7670_pkg;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_LOAD  = 4'd1,
    S_START = 4'd2,
    S_BYTE  = 4'd3,
    S_XBIT  = 4'd4,
    S_STOP  = 4'd5,
    S_GAP   = 4'd6,
    S_DELAY = 4'd7,
    S_DONE  = 4'd8
  } state_t;

  // ROM entry that ends the table walk.
  localparam logic [15:0] TERM       = 16'hFFFF;
  // ROM entry that inserts a 10 ms bus-silent pause.
  localparam logic [15:0] DELAY      = 16'hF0F0;
  localparam logic [7:0]  COM7_ADDR  = 8'h12;
  localparam logic [7:0]  COM7_RESET = 8'h80;

  // A write transaction has three phases: device address, register, data.
  function automatic logic [7:0] phase_byte(input logic [1:0]  phase,
                                            input logic [7:0]  dev,
                                            input logic [15:0] entry);
    case (phase)
      2'd0:    return dev;
      2'd1:    return entry[15:8];
      default: return entry[7:0];
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/ov7670_reg_rom.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ov7670_reg_rom                                                             |
// | Combinational register table: 8-bit index -> {reg_addr, reg_data}.         |
// | ROM_SEL = 0 : RGB444, QVGA 320x240 setup for the frame buffer.             |
// | ROM_SEL = 1 : single write COM7 = 0x04, then terminator.                   |
// | ROM_SEL = 2 : 10 ms pause, write CLKRC = 0x01, then terminator.            |
// | Any index past the end of a table reads as the terminator.                 |
// | Ports: idx  (in, 8)  table index                                           |
// |        data (out,16) table entry                                           |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module ov7670_reg_rom
  import ov7670_pkg::*;
#(
  parameter int ROM_SEL = 0
) (
  input  logic [7:0]  idx,
  output logic [15:0] data
);

  generate
    if (ROM_SEL == 1) begin : g_rom_single
      always_comb begin
        data = TERM;
        case (idx)
          8'd0:    data = 16'h1204;
          default: data = TERM;
        endcase
      end
    end else if (ROM_SEL == 2) begin : g_rom_delay
      always_comb begin
        data = TERM;
        case (idx)
          8'd0:    data = DELAY;
          8'd1:    data = 16'h1101;
          default: data = TERM;
        endcase
      end
    end else begin : g_rom_qvga_rgb444
      always_comb begin
        data = TERM;
        case (idx)
          8'd0:    data = 16'h1214; // COM7: QVGA, RGB output
          8'd1:    data = 16'h40D0; // COM15: full range, RGB565/444 family
          8'd2:    data = 16'h8C02; // RGB444 enable, xRGB word order
          8'd3:    data = 16'h1101; // CLKRC: prescale /2
          8'd4:    data = 16'h0C04; // COM3: scaling enable
          8'd5:    data = 16'h3E19; // COM14: manual scaling, PCLK /2
          8'd6:    data = 16'h7211; // downsample by 2 in both axes
          8'd7:    data = 16'h73F1; // DSP clock /2
          8'd8:    data = 16'h1716; // HSTART
          8'd9:    data = 16'h1804; // HSTOP
          8'd10:   data = 16'h3224; // HREF edge offsets
          8'd11:   data = 16'h1902; // VSTART
          8'd12:   data = 16'h1A7A; // VSTOP
          8'd13:   data = 16'h030A; // VREF edge offsets
          8'd14:   data = 16'hA202; // scaling PCLK delay
          default: data = TERM;
        endcase
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/ov7670_sccb_init.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ov7670_sccb_init                                                           |
// | Walks the OV7670 register table and issues one 3-phase SCCB write per      |
// | entry. Each SCCB bit is four quarter-bits; siod only moves while sioc is   |
// | low, except for the START and STOP edges.                                  |
// | Build option: OV7670_SOFT_RESET_EN - each walk is preceded by a write of   |
// | COM7 = 0x80 and a 10 ms pause while reg_idx holds at 0.                    |
// | Ports: clk (in) clock; reset (in) async active-low; start (in) walk pulse  |
// |        sioc (out) SCCB clock; siod_o / siod_oe (out) data and drive enable |
// |        busy, done (out) walk status; reg_idx (out, 8) current ROM index    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module ov7670_sccb_init
  import ov7670_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned SCCB_FREQ = 100_000,
  parameter logic [7:0]  DEV_ADDR  = 8'h42,
  parameter int          ROM_SEL   = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       sioc,
  output logic       siod_o,
  output logic       siod_oe,
  output logic       busy,
  output logic       done,
  output logic [7:0] reg_idx
);

  localparam int unsigned TICK_DIV   = CLK_FREQ / (4 * SCCB_FREQ);
  localparam int unsigned TICK_LAST  = (TICK_DIV > 1) ? TICK_DIV - 1 : 0;
  localparam int unsigned DELAY_CYC  = CLK_FREQ / 100;
  localparam int unsigned DELAY_LAST = (DELAY_CYC > 0) ? DELAY_CYC - 1 : 0;

  // Preamble stage: none, COM7 soft-reset write, post-reset pause.
  localparam logic [1:0] PRE_NONE  = 2'd0;
  localparam logic [1:0] PRE_WRITE = 2'd1;
  localparam logic [1:0] PRE_WAIT  = 2'd2;
`ifdef OV7670_SOFT_RESET_EN
  localparam logic [1:0] PRE_START = PRE_WRITE;
`else
  localparam logic [1:0] PRE_START = PRE_NONE;
`endif

  state_t      state;
  logic [31:0] tick_cnt;
  logic        tick;
  logic [1:0]  quarter;
  logic [2:0]  bit_cnt;
  logic [1:0]  byte_cnt;
  logic [7:0]  shift;
  logic [15:0] entry;
  logic [31:0] delay_cnt;
  logic [1:0]  pre;
  logic [15:0] rom_data;
  logic [15:0] cur_entry;

  ov7670_reg_rom #(.ROM_SEL(ROM_SEL)) u_rom (
    .idx  (reg_idx),
    .data (rom_data)
  );

  // During the preamble the table is bypassed with synthetic entries.
  always_comb begin
    cur_entry = rom_data;
    if (pre == PRE_WRITE)     cur_entry = {COM7_ADDR, COM7_RESET};
    else if (pre == PRE_WAIT) cur_entry = DELAY;
  end

  // Quarter-bit strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
      tick     <= 1'b0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
      tick     <= 1'b1;
    end else begin
      tick_cnt <= tick_cnt + 32'd1;
      tick     <= 1'b0;
    end
  end

  // Bus-driving states apply the action for quarter 'quarter' on each tick,
  // so every output level persists for exactly one quarter-bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      sioc      <= 1'b1;
      siod_o    <= 1'b1;
      siod_oe   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      reg_idx   <= 8'd0;
      quarter   <= 2'd0;
      bit_cnt   <= 3'd0;
      byte_cnt  <= 2'd0;
      shift     <= 8'd0;
      entry     <= 16'd0;
      delay_cnt <= 32'd0;
      pre       <= PRE_NONE;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state   <= S_LOAD;
            reg_idx <= 8'd0;
            done    <= 1'b0;
            busy    <= 1'b1;
            pre     <= PRE_START;
          end
        end

        S_LOAD: begin
          quarter <= 2'd0;
          // Index 255 ends the walk even without a terminator entry.
          if (pre == PRE_NONE && (cur_entry == TERM || reg_idx == 8'hFF)) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (cur_entry == DELAY) begin
            state     <= S_DELAY;
            delay_cnt <= 32'd0;
          end else begin
            state    <= S_START;
            entry    <= cur_entry;
            byte_cnt <= 2'd0;
            bit_cnt  <= 3'd0;
            shift    <= phase_byte(2'd0, DEV_ADDR, cur_entry);
          end
        end

        S_START: if (tick) begin
          quarter <= quarter + 2'd1;
          case (quarter)
            2'd0: begin
              sioc    <= 1'b1;
              siod_oe <= 1'b0;
            end
            2'd1: begin
              siod_o  <= 1'b0;
              siod_oe <= 1'b1;
            end
            default: begin
              sioc    <= 1'b0;
              quarter <= 2'd0;
              state   <= S_BYTE;
            end
          endcase
        end

        // Data moves one quarter after sioc falls so the two never coincide.
        S_BYTE: if (tick) begin
          quarter <= quarter + 2'd1;
          case (quarter)
            2'd0: sioc <= 1'b0;
            2'd1: begin
              siod_o  <= shift[7];
              siod_oe <= 1'b1;
            end
            2'd2: sioc <= 1'b1;
            default: begin
              shift   <= {shift[6:0], 1'b0};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= S_XBIT;
            end
          endcase
        end

        S_XBIT: if (tick) begin
          quarter <= quarter + 2'd1;
          case (quarter)
            2'd0: sioc    <= 1'b0;
            2'd1: siod_oe <= 1'b0;
            2'd2: sioc    <= 1'b1;
            default: begin
              if (byte_cnt == 2'd2) begin
                state <= S_STOP;
              end else begin
                byte_cnt <= byte_cnt + 2'd1;
                shift    <= phase_byte(byte_cnt + 2'd1, DEV_ADDR, entry);
                state    <= S_BYTE;
              end
            end
          endcase
        end

        S_STOP: if (tick) begin
          quarter <= quarter + 2'd1;
          case (quarter)
            2'd0: sioc <= 1'b0;
            2'd1: begin
              siod_o  <= 1'b0;
              siod_oe <= 1'b1;
            end
            2'd2: sioc <= 1'b1;
            default: begin
              siod_o  <= 1'b1;
              siod_oe <= 1'b0;
              state   <= S_GAP;
            end
          endcase
        end

        S_GAP: if (tick) begin
          quarter <= quarter + 2'd1;
          if (quarter == 2'd3) begin
            if (pre == PRE_WRITE)     pre     <= PRE_WAIT;
            else if (pre == PRE_WAIT) pre     <= PRE_NONE;
            else                      reg_idx <= reg_idx + 8'd1;
            state <= S_LOAD;
          end
        end

        S_DELAY: begin
          if (delay_cnt == DELAY_LAST) begin
            if (pre == PRE_WRITE)     pre     <= PRE_WAIT;
            else if (pre == PRE_WAIT) pre     <= PRE_NONE;
            else                      reg_idx <= reg_idx + 8'd1;
            state <= S_LOAD;
          end else begin
            delay_cnt <= delay_cnt + 32'd1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ov7670_sccb_init.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ov7670_sccb_init                                                        |
// | Three DUT instances (one per ROM table) share clock and reset. A bus       |
// | decoder turns sioc/siod into START / byte / STOP events which are compared |
// | with an event list derived from each table's entries.                      |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_ov7670_sccb_init;

  localparam int CLK_F     = 400_000;
  localparam int SCCB_F    = 10_000;
  localparam int DELAY_CYC = CLK_F / 100;
  localparam logic [15:0] EV_START = 16'h0100;
  localparam logic [15:0] EV_STOP  = 16'h0200;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] start;
  logic [2:0] sioc, siod_o, siod_oe, busy, done;
  logic [7:0] reg_idx [3];

  always #5 clk = ~clk;

  for (genvar i = 0; i < 3; i++) begin : g_dut
    ov7670_sccb_init #(
      .CLK_FREQ  (CLK_F),
      .SCCB_FREQ (SCCB_F),
      .DEV_ADDR  (8'h42),
      .ROM_SEL   (i)
    ) u_dut (
      .clk     (clk),
      .reset   (rst_n),
      .start   (start[i]),
      .sioc    (sioc[i]),
      .siod_o  (siod_o[i]),
      .siod_oe (siod_oe[i]),
      .busy    (busy[i]),
      .done    (done[i]),
      .reg_idx (reg_idx[i])
    );
  end

  int errors = 0;
  int checks = 0;

  // ---------------- bus decoder on the selected instance ----------------
  int          sel = 0;
  logic        mon_clr;
  logic        mon_c, mon_d, prev_c, prev_d;
  logic [7:0]  prev_idx, shreg;
  int          bitn, viol, idx_steps, idx_bad;
  int          cyc = 0;
  int          first_edge, last_stop, max_idle;
  logic [15:0] ev [$];

  assign mon_c = sioc[sel];
  assign mon_d = siod_oe[sel] ? siod_o[sel] : 1'b1;

  always @(negedge clk) begin
    cyc      <= cyc + 1;
    prev_c   <= mon_c;
    prev_d   <= mon_d;
    prev_idx <= reg_idx[sel];
    if (mon_clr) begin
      ev.delete();
      viol       <= 0;
      idx_steps  <= 0;
      idx_bad    <= 0;
      first_edge <= -1;
      last_stop  <= -1;
      max_idle   <= 0;
      bitn       <= 0;
    end else begin
      if (mon_c != prev_c && first_edge < 0) first_edge <= cyc;
      if (prev_c && mon_c && prev_d && !mon_d) begin
        ev.push_back(EV_START);
        bitn <= 0;
        if (last_stop >= 0 && cyc - last_stop > max_idle) max_idle <= cyc - last_stop;
      end else if (prev_c && mon_c && !prev_d && mon_d) begin
        ev.push_back(EV_STOP);
        last_stop <= cyc;
      end else if (mon_d != prev_d && (prev_c || mon_c)) begin
        viol <= viol + 1;
      end
      if (!prev_c && mon_c) begin
        if (bitn == 8) begin
          ev.push_back({8'h00, shreg});
          bitn <= 0;
          if (siod_oe[sel]) viol <= viol + 1;
        end else begin
          shreg <= {shreg[6:0], mon_d};
          bitn  <= bitn + 1;
        end
      end
      if (reg_idx[sel] != prev_idx) begin
        if (reg_idx[sel] == prev_idx + 8'd1) idx_steps <= idx_steps + 1;
        else if (reg_idx[sel] != 8'd0)       idx_bad   <= idx_bad + 1;
      end
    end
  end

  // ---------------- reference model ----------------
  logic [15:0] tbl [3][256];
  logic [15:0] exp_ev [$];
  int          exp_final;
  bit          exp_first_delay, exp_internal;

  task automatic push_write(input logic [15:0] e);
    exp_ev.push_back(EV_START);
    exp_ev.push_back(16'h0042);
    exp_ev.push_back({8'h00, e[15:8]});
    exp_ev.push_back({8'h00, e[7:0]});
    exp_ev.push_back(EV_STOP);
  endtask

  task automatic build_model(input int t);
    int idx;
    bit pend, any_write;
    exp_ev.delete();
    exp_first_delay = 0;
    exp_internal    = 0;
    pend            = 0;
    any_write       = 0;
`ifdef OV7670_SOFT_RESET_EN
    push_write(16'h1280);
    any_write = 1;
    pend      = 1;
`endif
    idx = 0;
    while (idx < 255 && tbl[t][idx] != 16'hFFFF) begin
      if (tbl[t][idx] == 16'hF0F0) begin
        pend = 1;
        if (!any_write) exp_first_delay = 1;
      end else begin
        if (any_write && pend) exp_internal = 1;
        pend = 0;
        push_write(tbl[t][idx]);
        any_write = 1;
      end
      idx++;
    end
    exp_final = idx;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_monitor(input int t);
    sel     = t;
    mon_clr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    mon_clr = 1'b0;
  endtask

  int start_cyc;

  task automatic run_walk(input int t, input int n_spur);
    int cycles, spur;
    bit got_done;
    build_model(t);
    clear_monitor(t);
    repeat ($urandom_range(1, 25)) @(negedge clk);
    start[t]  = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start[t] = 1'b0;
    check("busy_after_start", 32'(busy[t]), 32'd1);
    check("done_cleared", 32'(done[t]), 32'd0);
    check("idx_cleared", 32'(reg_idx[t]), 32'd0);
    cycles   = 0;
    spur     = n_spur;
    got_done = 0;
    while (!got_done && cycles < 60000) begin
      @(negedge clk);
      cycles++;
      if (start[t]) start[t] = 1'b0;
      else if (busy[t] && spur > 0 && $urandom_range(0, 499) == 0) begin
        start[t] = 1'b1;
        spur--;
      end
      if (done[t]) got_done = 1;
    end
    start[t] = 1'b0;
    @(negedge clk);
    check("done_within_budget", 32'(got_done), 32'd1);
    check("busy_low_at_done", 32'(busy[t]), 32'd0);
    check("idle_sioc", 32'(sioc[t]), 32'd1);
    check("idle_oe", 32'(siod_oe[t]), 32'd0);
    check("final_idx", 32'(reg_idx[t]), 32'(exp_final));
    check("idx_steps", 32'(idx_steps), 32'(exp_final));
    check("idx_bad", 32'(idx_bad), 32'd0);
    check("siod_hold_viol", 32'(viol), 32'd0);
    check("event_count", 32'(ev.size()), 32'(exp_ev.size()));
    for (int i = 0; i < exp_ev.size(); i++)
      check($sformatf("event%0d", i), (i < ev.size()) ? 32'(ev[i]) : 32'hDEAD, 32'(exp_ev[i]));
    check("silent_before_first_write",
          32'(first_edge >= 0 && first_edge - start_cyc >= DELAY_CYC), 32'(exp_first_delay));
    check("pause_between_writes", 32'(max_idle >= DELAY_CYC), 32'(exp_internal));
  endtask

  initial begin
    int cycles;
    for (int t = 0; t < 3; t++)
      for (int i = 0; i < 256; i++) tbl[t][i] = 16'hFFFF;
    tbl[0] = '{default: 16'hFFFF};
    tbl[2] = '{default: 16'hFFFF};
    tbl[1] = '{default: 16'hFFFF};
    // ROM_SEL 0 : RGB444 / QVGA setup
    tbl[0][0]  = 16'h1214; tbl[0][1]  = 16'h40D0; tbl[0][2]  = 16'h8C02;
    tbl[0][3]  = 16'h1101; tbl[0][4]  = 16'h0C04; tbl[0][5]  = 16'h3E19;
    tbl[0][6]  = 16'h7211; tbl[0][7]  = 16'h73F1; tbl[0][8]  = 16'h1716;
    tbl[0][9]  = 16'h1804; tbl[0][10] = 16'h3224; tbl[0][11] = 16'h1902;
    tbl[0][12] = 16'h1A7A; tbl[0][13] = 16'h030A; tbl[0][14] = 16'hA202;
    // ROM_SEL 1 : single write
    tbl[1][0] = 16'h1204;
    // ROM_SEL 2 : pause, then write
    tbl[2][0] = 16'hF0F0; tbl[2][1] = 16'h1101;

    mon_clr = 1'b1;
    start   = 3'b000;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    for (int t = 0; t < 3; t++) begin
      check("rst_sioc", 32'(sioc[t]), 32'd1);
      check("rst_siod_o", 32'(siod_o[t]), 32'd1);
      check("rst_siod_oe", 32'(siod_oe[t]), 32'd0);
      check("rst_busy", 32'(busy[t]), 32'd0);
      check("rst_done", 32'(done[t]), 32'd0);
      check("rst_idx", 32'(reg_idx[t]), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Single-write table, with start pulses while busy, then a full rerun.
    run_walk(1, 2);
    run_walk(1, 0);

    // Reset asserted in the middle of a byte aborts immediately.
    clear_monitor(1);
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    cycles = 0;
    while (ev.size() < 2 && cycles < 20000) begin
      @(negedge clk);
      cycles++;
    end
    check("reached_byte", 32'(ev.size() >= 2), 32'd1);
    repeat (15 + $urandom_range(0, 20)) @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_sioc", 32'(sioc[1]), 32'd1);
    check("abort_oe", 32'(siod_oe[1]), 32'd0);
    check("abort_busy", 32'(busy[1]), 32'd0);
    check("abort_done", 32'(done[1]), 32'd0);
    check("abort_idx", 32'(reg_idx[1]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_walk(1, 1);

    // Pause entry first, then a write.
    run_walk(2, 1);

    // Production table.
    run_walk(0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
